baseband_iq_capture: RTL and testbench
======================================

# baseband_iq_capture

Triggered capture buffer for the decimated baseband I/Q stream produced by the downsampler filters, which run after the downconversion CORDIC. It snapshots up to 2^AW consecutive valid I/Q pairs into on-chip RAM, either immediately or on a rising threshold crossing of I. Software reads the pairs back through a simple synchronous read port. It only observes the stream and never back-pressures it.

## Interface
- DW, 16, width of each I and Q sample (signed two's complement)
- AW, 10, RAM address width; capture depth = 2^AW pairs
- sys_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample strobe (downsampler ce_out); one pair per high cycle
- in_i  in  DW  decimated I sample, signed
- in_q  in  DW  decimated Q sample, signed
- arm  in  1  single-cycle pulse; starts a new capture, aborting any capture in progress
- abort  in  1  single-cycle pulse; returns to IDLE and keeps RAM contents
- trig_mode  in  1  0 = capture immediately, 1 = capture on I rising crossing of trig_level
- trig_level  in  DW  signed threshold for trig_mode=1
- n_samples  in  AW+1  number of pairs to capture; sampled on arm
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- wr_count  out  AW+1  pairs written in the current or last capture
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  2*DW  {I, Q} at rd_addr, with I in the upper half
- rd_valid  out  1  rd_data valid strobe

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset state is IDLE.
- Length latch on arm: n_samples=0 or n_samples>2^AW is latched as 2^AW. trig_mode and trig_level are also latched on arm.
- arm in any state:
  - wr_count <= 0 and prev_valid <= 0.
  - Next state is CAPTURE if the latched mode is 0, otherwise ARMED.
- abort in any state goes to IDLE. wr_count is held. If abort and arm occur in the same cycle, abort wins.
- ARMED:
  - On every in_valid, prev_i <= in_i and prev_valid <= 1.
  - Trigger condition: in_valid && prev_valid && prev_i < trig_level && in_i >= trig_level, using signed compare.
  - The triggering sample is written to address 0, wr_count becomes 1, and the state moves to CAPTURE.
  - If the latched length is 1, the state goes directly to DONE.
- CAPTURE:
  - On each in_valid, {in_i, in_q} is written to RAM[wr_count[AW-1:0]] and wr_count increments.
  - When the incremented wr_count equals the latched length, the state moves to DONE.
  - Cycles without in_valid write nothing.
- DONE: holds until arm or abort. in_valid is ignored and the RAM is frozen.
- IDLE: in_valid is ignored.
- Reads are allowed in every state, including during capture. Reads return the current RAM contents; addresses not yet written return stale data.
- RAM: one write port and one read port, both on sys_clk, single-clock simple dual-port inferred BRAM. There is no write-to-read forwarding: a same-address collision returns the old data.

## Timing
- Reset values:
  - busy=0, done=0, wr_count=0
  - rd_valid=0, rd_data=0
  - prev_valid=0, state IDLE
- RAM contents are not reset.
- State update: arm at cycle t makes busy=1 at t+1 (or done=1 at t+1 never; done requires a capture).
- Write latency: in_valid at cycle t writes RAM and updates wr_count, both visible at t+1.
- Completion: the final write at cycle t gives done=1 and busy=0 at t+1.
- Trigger latency: the crossing sample at cycle t sets busy state CAPTURE and wr_count=1 at t+1.
- Read latency: rd_en at cycle t gives rd_valid=1 and rd_data=RAM[rd_addr] at t+1. When rd_en=0, rd_valid=0 and rd_data holds its last value.
- Throughput: in_valid may be high every cycle (full rate, no decimation) with no lost samples.
- Reset mid-capture: all outputs take their reset values immediately (asynchronous), and the capture is discarded.

## Test plan
- Immediate mode: n_samples=8, trig_mode=0, arm, then 10 in_valid pulses spaced 4 cycles apart with I=k, Q=-k.
  - done rises 1 cycle after the 8th pulse and wr_count=8.
  - Reading addresses 0..7 returns {k, -k} for k=0..7, each with rd_valid 1 cycle after rd_en.
- Level trigger: trig_level=100, I ramps -200..+200 in steps of 50 on every in_valid.
  - The first stored I is 100 (from 50→100).
  - No trigger fires on the first sample after arm, even when that sample is ≥100.
- Boundary length:
  - n_samples=0 with AW=4 captures 16 pairs, wr_count=16 (wrap never reached).
  - n_samples=1 in trig mode goes ARMED→DONE on the trigger sample.
- Abort and arm:
  - abort during CAPTURE after 3 writes gives IDLE, busy=0, done=0, wr_count=3.
  - Simultaneous arm+abort gives IDLE.
  - arm during DONE restarts with wr_count=0.
- Async reset: assert rst_n=0 mid-capture between clock edges.
  - busy, done, wr_count, rd_valid and rd_data go to 0 before the next edge.
  - After release the block is in IDLE and in_valid has no effect.
- Back-to-back: in_valid high continuously, n_samples=32, concurrent reads of address 0.
  - All 32 consecutive pairs are stored.
  - Address-0 reads return the new data from 2 cycles after its write onward.

Source files
------------

// File: rtl/baseband_iq_capture_if.sv
// Port bundle for the baseband I/Q capture buffer: stream input, capture
// control/status and the synchronous read-back port.
interface baseband_iq_capture_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  // in_valid is a one-cycle strobe with no ready: the capture block only
  // observes the stream, and every high cycle carries one I/Q pair that is
  // taken or ignored on that edge. rd_en/rd_valid follow the same rule,
  // rd_valid answering rd_en exactly one cycle later.
  logic                 in_valid;
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 arm;
  logic                 abort;
  logic                 trig_mode;
  logic signed [DW-1:0] trig_level;
  logic [AW:0]          n_samples;
  logic                 busy;
  logic                 done;
  logic [AW:0]          wr_count;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic [2*DW-1:0]      rd_data;
  logic                 rd_valid;

  modport master (
    output in_valid, in_i, in_q, arm, abort, trig_mode, trig_level, n_samples,
    output rd_en, rd_addr,
    input  busy, done, wr_count, rd_data, rd_valid
  );

  modport slave (
    input  in_valid, in_i, in_q, arm, abort, trig_mode, trig_level, n_samples,
    input  rd_en, rd_addr,
    output busy, done, wr_count, rd_data, rd_valid
  );
endinterface

// File: rtl/baseband_iq_capture.sv
// Triggered snapshot of the decimated I/Q stream into a simple dual-port RAM,
// started immediately or on a rising I threshold crossing; read back by software.
module baseband_iq_capture #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  baseband_iq_capture_if.slave bus,
  output logic [1:0]           o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] LEN_MAX = DEPTH[AW:0];

  state_t               r_state;
  state_t               w_next_state;
  logic [AW:0]          r_len;
  logic [AW:0]          r_wr_count;
  logic [AW:0]          w_wr_count_next;
  logic [AW:0]          w_cnt_inc;
  logic [AW:0]          w_len_arm;
  logic signed [DW-1:0] r_level;
  logic signed [DW-1:0] r_prev_i;
  logic signed [DW-1:0] w_prev_i_next;
  logic                 r_prev_valid;
  logic                 w_prev_valid_next;
  logic                 w_we;
  logic                 w_cross;
  logic [AW-1:0]        w_wr_addr;
  logic [2*DW-1:0]      r_mem [DEPTH];
  logic [2*DW-1:0]      r_rd_data;
  logic                 r_rd_valid;

  // Zero or an oversize request both mean "fill the whole RAM".
  assign w_len_arm = (bus.n_samples == '0 || bus.n_samples > LEN_MAX) ? LEN_MAX : bus.n_samples;
  assign w_cnt_inc = r_wr_count + (AW+1)'(1);
  assign w_wr_addr = r_wr_count[AW-1:0];
  assign w_cross   = bus.in_valid && r_prev_valid &&
                     ($signed(r_prev_i) < $signed(r_level)) &&
                     ($signed(bus.in_i) >= $signed(r_level));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_count   <= '0;
      r_prev_valid <= 1'b0;
      r_prev_i     <= '0;
      r_len        <= LEN_MAX;
      r_level      <= '0;
    end else begin
      r_state      <= w_next_state;
      r_wr_count   <= w_wr_count_next;
      r_prev_valid <= w_prev_valid_next;
      r_prev_i     <= w_prev_i_next;
      if (bus.arm && !bus.abort) begin
        r_len   <= w_len_arm;
        r_level <= bus.trig_level;
      end
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_wr_count_next   = r_wr_count;
    w_prev_valid_next = r_prev_valid;
    w_prev_i_next     = r_prev_i;
    w_we              = 1'b0;
    if (bus.abort) begin
      w_next_state = S_IDLE;
    end else if (bus.arm) begin
      w_wr_count_next   = '0;
      w_prev_valid_next = 1'b0;
      w_next_state      = bus.trig_mode ? S_ARMED : S_CAPTURE;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (bus.in_valid) begin
            w_prev_i_next     = bus.in_i;
            w_prev_valid_next = 1'b1;
          end
          // wr_count is zero while armed, so the trigger sample lands at address 0.
          if (w_cross) begin
            w_we            = 1'b1;
            w_wr_count_next = w_cnt_inc;
            w_next_state    = (w_cnt_inc == r_len) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (bus.in_valid) begin
            w_we            = 1'b1;
            w_wr_count_next = w_cnt_inc;
            if (w_cnt_inc == r_len) w_next_state = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_we) r_mem[w_wr_addr] <= {bus.in_i, bus.in_q};
  end

  // Read in the same edge as a write returns the old word (no forwarding).
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= r_mem[bus.rd_addr];
    end
  end

  assign bus.busy     = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.wr_count = r_wr_count;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_baseband_iq_capture.sv
// Directed bench for baseband_iq_capture: a 64-deep instance for most scenarios
// and a 16-deep instance for the full-depth length case.
module tb_baseband_iq_capture;
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  dbg;
  logic [1:0]  dbg4;

  baseband_iq_capture_if #(.DW(16), .AW(6)) bus  ();
  baseband_iq_capture_if #(.DW(16), .AW(4)) bus4 ();

  baseband_iq_capture #(.DW(16), .AW(6)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus.slave), .o_dbg_state(dbg));
  baseband_iq_capture #(.DW(16), .AW(4)) u_dut4 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus4.slave), .o_dbg_state(dbg4));

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic arm_cap(input logic [6:0] n, input logic mode, input logic [15:0] lvl);
    bus.n_samples = n; bus.trig_mode = mode; bus.trig_level = lvl; bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    bus.in_valid = 1'b1; bus.in_i = i; bus.in_q = q;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_i = 0; bus.in_q = 0; bus.arm = 0; bus.abort = 0;
    bus.trig_mode = 0; bus.trig_level = 0; bus.n_samples = 0; bus.rd_en = 0; bus.rd_addr = 0;
    bus4.in_valid = 0; bus4.in_i = 0; bus4.in_q = 0; bus4.arm = 0; bus4.abort = 0;
    bus4.trig_mode = 0; bus4.trig_level = 0; bus4.n_samples = 0; bus4.rd_en = 0; bus4.rd_addr = 0;
    #2;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_checks++; if (bus.wr_count !== 7'd0) begin n_fail++; $display("FAIL rst_wr_count: got %0d want 0", bus.wr_count); end
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd: got %b/%h want 0/0", bus.rd_valid, bus.rd_data); end
    n_checks++; if (dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (dbg !== 2'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got state %0d busy %b want 0 0", dbg, bus.busy); end
  endtask

  task automatic test_immediate();
    logic [31:0] e;
    logic [31:0] last;
    arm_cap(7'd8, 1'b0, 16'd0);
    n_checks++; if (bus.busy !== 1'b1 || dbg !== 2'd2) begin n_fail++; $display("FAIL imm_arm: got busy %b state %0d want 1 2", bus.busy, dbg); end
    for (int k = 0; k < 10; k++) begin
      send(16'(k), 16'(-k));
      if (k == 6) begin
        n_checks++; if (bus.done !== 1'b0 || bus.wr_count !== 7'd7) begin n_fail++; $display("FAIL imm_k6: got done %b cnt %0d want 0 7", bus.done, bus.wr_count); end
      end
      if (k == 7) begin
        n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_count !== 7'd8) begin n_fail++; $display("FAIL imm_done: got done %b busy %b cnt %0d want 1 0 8", bus.done, bus.busy, bus.wr_count); end
      end
      repeat (3) tick();
    end
    n_checks++; if (bus.done !== 1'b1 || bus.wr_count !== 7'd8) begin n_fail++; $display("FAIL imm_hold: got done %b cnt %0d want 1 8", bus.done, bus.wr_count); end
    for (int k = 0; k < 8; k++) begin
      e = {16'(k), 16'(-k)};
      rd(6'(k));
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin n_fail++; $display("FAIL imm_read%0d: got %b/%h want 1/%h", k, bus.rd_valid, bus.rd_data, e); end
    end
    last = {16'd7, 16'hFFF9};
    tick();
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== last) begin n_fail++; $display("FAIL imm_rd_hold: got %b/%h want 0/%h", bus.rd_valid, bus.rd_data, last); end
  endtask

  task automatic test_full_depth();
    bus4.n_samples = 5'd0; bus4.trig_mode = 1'b0; bus4.arm = 1'b1;
    tick();
    bus4.arm = 1'b0;
    for (int k = 0; k < 18; k++) begin
      bus4.in_valid = 1'b1; bus4.in_i = 16'(k + 500); bus4.in_q = 16'(k);
      tick();
      if (k == 14) begin
        n_checks++; if (bus4.wr_count !== 5'd15 || bus4.done !== 1'b0) begin n_fail++; $display("FAIL depth_k14: got cnt %0d done %b want 15 0", bus4.wr_count, bus4.done); end
      end
      if (k == 15) begin
        n_checks++; if (bus4.wr_count !== 5'd16 || bus4.done !== 1'b1) begin n_fail++; $display("FAIL depth_done: got cnt %0d done %b want 16 1", bus4.wr_count, bus4.done); end
      end
    end
    bus4.in_valid = 1'b0;
    n_checks++; if (bus4.wr_count !== 5'd16 || dbg4 !== 2'd3) begin n_fail++; $display("FAIL depth_hold: got cnt %0d state %0d want 16 3", bus4.wr_count, dbg4); end
    bus4.rd_en = 1'b1; bus4.rd_addr = 4'd0;
    tick();
    n_checks++; if (bus4.rd_data !== {16'd500, 16'd0}) begin n_fail++; $display("FAIL depth_rd0: got %h want %h", bus4.rd_data, {16'd500, 16'd0}); end
    bus4.rd_addr = 4'd15;
    tick();
    bus4.rd_en = 1'b0;
    n_checks++; if (bus4.rd_data !== {16'd515, 16'd15}) begin n_fail++; $display("FAIL depth_rd15: got %h want %h", bus4.rd_data, {16'd515, 16'd15}); end
  endtask

  task automatic test_level_trigger();
    exp_q.delete();
    arm_cap(7'd3, 1'b1, 16'd100);
    n_checks++; if (dbg !== 2'd1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL lvl_armed: got state %0d busy %b want 1 1", dbg, bus.busy); end
    for (int v = -200; v <= 200; v += 50) begin
      send(16'(v), 16'(v / 2));
      if (v >= 100) exp_q.push_back({16'(v), 16'(v / 2)});
      if (v == 50) begin
        n_checks++; if (dbg !== 2'd1 || bus.wr_count !== 7'd0) begin n_fail++; $display("FAIL lvl_pre: got state %0d cnt %0d want 1 0", dbg, bus.wr_count); end
      end
      if (v == 100) begin
        n_checks++; if (dbg !== 2'd2 || bus.wr_count !== 7'd1) begin n_fail++; $display("FAIL lvl_trig: got state %0d cnt %0d want 2 1", dbg, bus.wr_count); end
      end
    end
    n_checks++; if (bus.done !== 1'b1 || bus.wr_count !== 7'd3) begin n_fail++; $display("FAIL lvl_done: got done %b cnt %0d want 1 3", bus.done, bus.wr_count); end
    for (int a = 0; a < 3; a++) begin
      rd(6'(a));
      n_checks++; if (bus.rd_data !== exp_q[a]) begin n_fail++; $display("FAIL lvl_read%0d: got %h want %h", a, bus.rd_data, exp_q[a]); end
    end
  endtask

  task automatic test_first_sample_and_len1();
    arm_cap(7'd1, 1'b1, 16'd100);
    send(16'd150, 16'd1);
    n_checks++; if (dbg !== 2'd1 || bus.wr_count !== 7'd0) begin n_fail++; $display("FAIL first_no_trig: got state %0d cnt %0d want 1 0", dbg, bus.wr_count); end
    send(16'd160, 16'd2);
    n_checks++; if (dbg !== 2'd1) begin n_fail++; $display("FAIL above_no_trig: got state %0d want 1", dbg); end
    send(16'd0, 16'd3);
    send(16'd120, 16'd4);
    n_checks++; if (dbg !== 2'd3 || bus.done !== 1'b1 || bus.wr_count !== 7'd1) begin n_fail++; $display("FAIL len1_done: got state %0d done %b cnt %0d want 3 1 1", dbg, bus.done, bus.wr_count); end
    rd(6'd0);
    n_checks++; if (bus.rd_data !== {16'd120, 16'd4}) begin n_fail++; $display("FAIL len1_read: got %h want %h", bus.rd_data, {16'd120, 16'd4}); end
  endtask

  task automatic test_abort_arm();
    arm_cap(7'd8, 1'b0, 16'd0);
    send(16'd11, 16'd1); send(16'd12, 16'd2); send(16'd13, 16'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++; if (dbg !== 2'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== 7'd3) begin n_fail++; $display("FAIL abort: got state %0d busy %b done %b cnt %0d want 0 0 0 3", dbg, bus.busy, bus.done, bus.wr_count); end
    send(16'd14, 16'd4);
    n_checks++; if (dbg !== 2'd0 || bus.wr_count !== 7'd3) begin n_fail++; $display("FAIL idle_ignore: got state %0d cnt %0d want 0 3", dbg, bus.wr_count); end
    bus.abort = 1'b1;
    arm_cap(7'd5, 1'b0, 16'd0);
    bus.abort = 1'b0;
    n_checks++; if (dbg !== 2'd0 || bus.busy !== 1'b0 || bus.wr_count !== 7'd3) begin n_fail++; $display("FAIL arm_abort: got state %0d busy %b cnt %0d want 0 0 3", dbg, bus.busy, bus.wr_count); end
    arm_cap(7'd2, 1'b0, 16'd0);
    send(16'd21, 16'd1); send(16'd22, 16'd2);
    n_checks++; if (bus.done !== 1'b1 || bus.wr_count !== 7'd2) begin n_fail++; $display("FAIL short_done: got done %b cnt %0d want 1 2", bus.done, bus.wr_count); end
    arm_cap(7'd4, 1'b0, 16'd0);
    n_checks++; if (dbg !== 2'd2 || bus.done !== 1'b0 || bus.wr_count !== 7'd0) begin n_fail++; $display("FAIL rearm_done: got state %0d done %b cnt %0d want 2 0 0", dbg, bus.done, bus.wr_count); end
  endtask

  task automatic test_async_reset();
    arm_cap(7'd8, 1'b0, 16'd0);
    send(16'h1234, 16'h5678);
    bus.rd_en = 1'b1; bus.rd_addr = 6'd0;
    tick();
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h12345678) begin n_fail++; $display("FAIL pre_rst_read: got %b/%h want 1/12345678", bus.rd_valid, bus.rd_data); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== 7'd0) begin n_fail++; $display("FAIL async_ctl: got busy %b done %b cnt %0d want 0 0 0", bus.busy, bus.done, bus.wr_count); end
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL async_rd: got %b/%h want 0/0", bus.rd_valid, bus.rd_data); end
    bus.rd_en = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    send(16'd7, 16'd7);
    n_checks++; if (dbg !== 2'd0 || bus.busy !== 1'b0 || bus.wr_count !== 7'd0) begin n_fail++; $display("FAIL post_rst_idle: got state %0d busy %b cnt %0d want 0 0 0", dbg, bus.busy, bus.wr_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    exp_q.delete();
    arm_cap(7'd32, 1'b0, 16'd0);
    for (int k = 0; k < 32; k++) begin
      bus.in_valid = 1'b1; bus.in_i = 16'(k * 3 + 1); bus.in_q = 16'(-(k * 5) - 2);
      exp_q.push_back({16'(k * 3 + 1), 16'(-(k * 5) - 2)});
      bus.rd_en = 1'b1; bus.rd_addr = 6'd0;
      tick();
      w = (k == 0) ? 32'h12345678 : exp_q[0];
      n_checks++; if (bus.wr_count !== 7'(k + 1)) begin n_fail++; $display("FAIL b2b_cnt%0d: got %0d want %0d", k, bus.wr_count, k + 1); end
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== w) begin n_fail++; $display("FAIL b2b_rd0_%0d: got %b/%h want 1/%h", k, bus.rd_valid, bus.rd_data, w); end
      n_checks++; if (bus.done !== (k == 31)) begin n_fail++; $display("FAIL b2b_done%0d: got %b want %b", k, bus.done, (k == 31)); end
    end
    bus.in_valid = 1'b0; bus.rd_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd(6'(a));
      n_checks++; if (bus.rd_data !== exp_q[a]) begin n_fail++; $display("FAIL b2b_read%0d: got %h want %h", a, bus.rd_data, exp_q[a]); end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_full_depth();
    test_level_trigger();
    test_first_sample_and_len1();
    test_abort_arm();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
